// File: rtl/dmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_if
// Bundles every signal between the data-memory access controller, the
// pipeline (EX/MEM register side) and the external data memory.
//   Pipeline side : mem_read, mem_write, alu_result, out2 (requests in)
//                   busy_wait, read_data_out, misaligned, err (status out)
//   Memory side   : mem_addr, mem_wdata, mem_be, mem_rd, mem_wr (requests out)
//                   mem_rdata, mem_ack (completion in)
// Modports:
//   slave  - the controller itself
//   master - the environment (pipeline + memory) that drives the controller
// ---------------------------------------------------------------------------
interface dmem_access_ctrl_if;
  logic [2:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] alu_result;
  logic [31:0] out2;
  logic        busy_wait;
  logic [31:0] read_data_out;
  logic        misaligned;
  logic        err;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  mem_read, mem_write, alu_result, out2, mem_rdata, mem_ack,
    output busy_wait, read_data_out, misaligned, err,
           mem_addr, mem_wdata, mem_be, mem_rd, mem_wr
  );

  modport master (
    output mem_read, mem_write, alu_result, out2, mem_rdata, mem_ack,
    input  busy_wait, read_data_out, misaligned, err,
           mem_addr, mem_wdata, mem_be, mem_rd, mem_wr
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Data-memory access controller for the MEM stage. Decodes load/store codes,
// rejects misaligned accesses, issues one registered read or write strobe to
// the memory, stalls the pipeline until the memory acknowledges (or a 255
// cycle timeout expires) and returns the byte/half/word load result with the
// proper sign or zero extension.
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - dmem_access_ctrl_if.slave (pipeline request/status and memory bus)
// ---------------------------------------------------------------------------
module dmem_access_ctrl (
  input  logic              clk_i,
  input  logic              rst_i,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LW  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;
  localparam logic [2:0] ST_SB  = 3'd1;
  localparam logic [2:0] ST_SH  = 3'd2;
  localparam logic [2:0] ST_SW  = 3'd3;

  // The counter is cleared on WAIT entry and stepped once per WAIT cycle, so
  // it reaches 255 at the edge that closes the 255th WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'd254;

  // Byte/half selection from the returned word followed by extension.
  function automatic logic [31:0] load_extend(
    input logic [2:0]  code,
    input logic [1:0]  off,
    input logic [31:0] word
  );
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [7:0]  b;
    logic [15:0] h;
    byte_sh = word >> {off, 3'b000};
    half_sh = word >> {off[1], 4'b0000};
    b = byte_sh[7:0];
    h = half_sh[15:0];
    case (code)
      LD_LB:   load_extend = {{24{b[7]}}, b};
      LD_LH:   load_extend = {{16{h[15]}}, h};
      LD_LW:   load_extend = word;
      LD_LBU:  load_extend = {24'd0, b};
      LD_LHU:  load_extend = {16'd0, h};
      default: load_extend = 32'd0;
    endcase
  endfunction

  // Store data replicated onto every lane it could land in.
  function automatic logic [31:0] store_lanes(
    input logic [2:0]  code,
    input logic [31:0] data
  );
    case (code)
      ST_SB:   store_lanes = {4{data[7:0]}};
      ST_SH:   store_lanes = {2{data[15:0]}};
      ST_SW:   store_lanes = data;
      default: store_lanes = 32'd0;
    endcase
  endfunction

  // Byte enables for a store at the given byte offset.
  function automatic logic [3:0] store_be(
    input logic [2:0] code,
    input logic [1:0] off
  );
    case (code)
      ST_SB:   store_be = 4'b0001 << off;
      ST_SH:   store_be = off[1] ? 4'b1100 : 4'b0011;
      ST_SW:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  ld_code_q, ld_code_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        st_valid;
  logic        ld_valid;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        req_ok;
  logic        busy;

  // Request decode: a valid store masks any load presented alongside it.
  always_comb begin
    st_valid = 1'b0;
    ld_valid = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (bus.mem_write)
      ST_SB:   st_valid = 1'b1;
      ST_SH: begin
        st_valid = 1'b1;
        is_half  = 1'b1;
      end
      ST_SW: begin
        st_valid = 1'b1;
        is_word  = 1'b1;
      end
      default: st_valid = 1'b0;
    endcase
    if (!st_valid) begin
      case (bus.mem_read)
        LD_LB, LD_LBU: ld_valid = 1'b1;
        LD_LH, LD_LHU: begin
          ld_valid = 1'b1;
          is_half  = 1'b1;
        end
        LD_LW: begin
          ld_valid = 1'b1;
          is_word  = 1'b1;
        end
        default: ld_valid = 1'b0;
      endcase
    end else begin
      ld_valid = 1'b0;
    end
    misaligned = (is_half & bus.alu_result[0]) |
                 (is_word & (bus.alu_result[1:0] != 2'b00));
    req_ok     = (st_valid | ld_valid) & ~misaligned;
  end

  // Next-state and datapath update for the IDLE/WAIT/DONE access sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    ld_code_d = ld_code_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          busy     = 1'b1;
          state_d  = S_WAIT;
          cnt_d    = 8'd0;
          mem_rd_d = ld_valid;
          mem_wr_d = st_valid;
          addr_d   = bus.alu_result[31:2];
          off_d    = bus.alu_result[1:0];
          if (st_valid) begin
            wdata_d   = store_lanes(bus.mem_write, bus.out2);
            be_d      = store_be(bus.mem_write, bus.alu_result[1:0]);
            ld_code_d = 3'd0;
          end else begin
            wdata_d   = 32'd0;
            be_d      = 4'b1111;
            ld_code_d = bus.mem_read;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (bus.mem_ack) begin
          state_d  = S_DONE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (mem_rd_q) begin
            rdata_d = load_extend(ld_code_q, off_q, bus.mem_rdata);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Give up: release the pipeline and flag the error in DONE.
          state_d  = S_DONE;
          cnt_d    = cnt_q + 8'd1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          err_d    = 1'b1;
          if (mem_rd_q) begin
            rdata_d = 32'd0;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // The pipeline advances this cycle; the held request is not reissued.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output storage with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      addr_q    <= 30'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'b0000;
      ld_code_q <= 3'd0;
      off_q     <= 2'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      ld_code_q <= ld_code_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // The stall is combinational so the pipeline freezes in the request cycle;
  // reset overrides it so nothing is accepted while reset is held.
  assign bus.busy_wait     = busy & ~rst_i;
  assign bus.misaligned    = misaligned;
  assign bus.read_data_out = rdata_q;
  assign bus.err           = err_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_be        = be_q;
  assign bus.mem_rd        = mem_rd_q;
  assign bus.mem_wr        = mem_wr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] model_rdo;

  dmem_access_ctrl_if bus();

  dmem_access_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Observations gathered by run_access.
  int          obs_busy;
  logic        obs_mis;
  logic [29:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_rd, obs_wr, obs_err;
  logic [31:0] obs_rdo;
  logic        obs_busy_post, obs_rd_post, obs_wr_post, obs_err_post;

  // ---------------- reference model (size/alignment arithmetic) -----------
  function automatic int acc_size(input logic [2:0] rd, input logic [2:0] wr);
    if (wr == 3'd1) return 1;
    if (wr == 3'd2) return 2;
    if (wr == 3'd3) return 4;
    if (rd == 3'd1 || rd == 3'd4) return 1;
    if (rd == 3'd2 || rd == 3'd5) return 2;
    if (rd == 3'd3) return 4;
    return 0;
  endfunction

  function automatic bit is_store(input logic [2:0] wr);
    return (wr >= 3'd1) && (wr <= 3'd3);
  endfunction

  function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] d);
    longint unsigned v;
    longint unsigned r;
    v = longint'(d) & ((64'd1 << (8 * size)) - 64'd1);
    r = 64'd0;
    for (int i = 0; i < 4 / size; i++) r = r + (v << (8 * size * i));
    return r[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input int size, input int off);
    logic [31:0] t;
    t = ((32'd1 << size) - 32'd1) << off;
    return t[3:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] rd, input int off,
                                           input logic [31:0] word);
    longint unsigned w;
    longint unsigned v;
    int size;
    size = acc_size(rd, 3'd0);
    w = {32'd0, word};
    v = (w >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
    if ((rd == 3'd1 || rd == 3'd2) && v >= (64'd1 << (8 * size - 1)))
      v = v - (64'd1 << (8 * size));
    return v[31:0];
  endfunction

  // ---------------- stimulus driver ---------------------------------------
  // Presents one request, acks in WAIT cycle ack_at (0 = never), samples the
  // bus each cycle, then drops the request and samples the following cycle.
  task automatic run_access(input logic [2:0] rd, input logic [2:0] wr,
                            input logic [31:0] addr, input logic [31:0] o2,
                            input logic [31:0] rdat, input int ack_at);
    int cyc;
    bit done;
    @(posedge clk); #1;
    bus.mem_read = rd; bus.mem_write = wr; bus.alu_result = addr; bus.out2 = o2;
    cyc = 0; done = 1'b0; obs_busy = 0; obs_mis = 1'b0;
    obs_rd = 1'b0; obs_wr = 1'b0; obs_addr = 30'd0; obs_wdata = 32'd0; obs_be = 4'd0;
    while (!done) begin
      if (ack_at > 0 && cyc == ack_at) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rdat;
      end else begin
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      if (cyc == 0) obs_mis = bus.misaligned;
      if (cyc == 1) begin
        obs_rd = bus.mem_rd; obs_wr = bus.mem_wr; obs_addr = bus.mem_addr;
        obs_wdata = bus.mem_wdata; obs_be = bus.mem_be;
      end
      if (bus.busy_wait) begin
        obs_busy++;
        if (cyc >= 300) done = 1'b1;
        else begin @(posedge clk); #1; cyc++; end
      end else begin
        done = 1'b1;
      end
    end
    obs_err = bus.err; obs_rdo = bus.read_data_out;
    @(posedge clk); #1;
    bus.mem_read = 3'd0; bus.mem_write = 3'd0; bus.mem_ack = 1'b0;
    @(negedge clk);
    obs_busy_post = bus.busy_wait; obs_rd_post = bus.mem_rd;
    obs_wr_post = bus.mem_wr; obs_err_post = bus.err;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus.mem_read = 3'd3; bus.alu_result = 32'h20; bus.mem_ack = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy_wait, bus.mem_rd, bus.mem_wr, bus.err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000",
                         {bus.busy_wait, bus.mem_rd, bus.mem_wr, bus.err});
    end
    n_cmp++;
    if ({bus.read_data_out, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 98'd0) begin
      n_fail++; $display("FAIL reset_data: rdo=%h addr=%h wdata=%h be=%b expected all 0",
                         bus.read_data_out, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy_wait, bus.mem_rd} !== 2'b00) begin
      n_fail++; $display("FAIL reset_hold: busy/rd got %b expected 00", {bus.busy_wait, bus.mem_rd});
    end
    bus.mem_read = 3'd0; bus.mem_ack = 1'b0;
    rst = 1'b0;
    model_rdo = 32'd0;
  endtask

  task automatic test_lb_sign();
    run_access(3'd1, 3'd0, 32'h103, $urandom, 32'h80AABBCC, 2);
    model_rdo = 32'hFFFFFF80;
    n_cmp++;
    if (obs_busy !== 3) begin
      n_fail++; $display("FAIL lb_busy: got %0d cycles expected 3", obs_busy);
    end
    n_cmp++;
    if ({obs_rd, obs_wr, obs_be, obs_addr} !== {2'b10, 4'b1111, 30'h40}) begin
      n_fail++; $display("FAIL lb_req: rd=%b wr=%b be=%b addr=%h expected 1 0 1111 40",
                         obs_rd, obs_wr, obs_be, obs_addr);
    end
    n_cmp++;
    if (obs_rdo !== model_rdo) begin
      n_fail++; $display("FAIL lb_data: got %h expected %h", obs_rdo, model_rdo);
    end
    n_cmp++;
    if ({obs_err, obs_busy_post, obs_rd_post, obs_err_post} !== 4'b0000) begin
      n_fail++; $display("FAIL lb_after: err/busy/rd/err got %b expected 0000",
                         {obs_err, obs_busy_post, obs_rd_post, obs_err_post});
    end
  endtask

  task automatic test_sh();
    run_access(3'd0, 3'd2, 32'h202, 32'h1234ABCD, $urandom, 1);
    n_cmp++;
    if (obs_busy !== 2) begin
      n_fail++; $display("FAIL sh_busy: got %0d expected 2", obs_busy);
    end
    n_cmp++;
    if ({obs_rd, obs_wr, obs_be, obs_addr, obs_wdata} !== {2'b01, 4'b1100, 30'h80, 32'hABCDABCD}) begin
      n_fail++; $display("FAIL sh_req: rd=%b wr=%b be=%b addr=%h wdata=%h expected 0 1 1100 80 abcdabcd",
                         obs_rd, obs_wr, obs_be, obs_addr, obs_wdata);
    end
    n_cmp++;
    if (obs_rdo !== model_rdo) begin
      n_fail++; $display("FAIL sh_rdo: got %h expected %h", obs_rdo, model_rdo);
    end
  endtask

  task automatic test_both_valid();
    logic [31:0] d;
    d = $urandom;
    run_access(3'd3, 3'd3, 32'h10, d, $urandom, 1);
    n_cmp++;
    if ({obs_rd, obs_wr, obs_be, obs_wdata, obs_addr} !== {2'b01, 4'b1111, d, 30'h4}) begin
      n_fail++; $display("FAIL both_req: rd=%b wr=%b be=%b wdata=%h addr=%h expected 0 1 1111 %h 4",
                         obs_rd, obs_wr, obs_be, obs_wdata, obs_addr, d);
    end
    n_cmp++;
    if (obs_rdo !== model_rdo) begin
      n_fail++; $display("FAIL both_rdo: got %h expected %h", obs_rdo, model_rdo);
    end
  endtask

  task automatic test_misaligned();
    run_access(3'd3, 3'd0, 32'h101, 32'd0, $urandom, 1);
    n_cmp++;
    if ({obs_mis, obs_busy != 0, obs_rd_post, obs_busy_post} !== 4'b1000) begin
      n_fail++; $display("FAIL lw_misaligned: mis=%b busy=%0d rd=%b expected 1 0 0",
                         obs_mis, obs_busy, obs_rd_post);
    end
  endtask

  task automatic test_timeout();
    run_access(3'd5, 3'd0, 32'h8, 32'd0, 32'd0, 0);
    model_rdo = 32'd0;
    n_cmp++;
    if (obs_busy !== 256) begin
      n_fail++; $display("FAIL timeout_busy: got %0d expected 256", obs_busy);
    end
    n_cmp++;
    if ({obs_err, obs_rdo} !== {1'b1, model_rdo}) begin
      n_fail++; $display("FAIL timeout_done: err=%b rdo=%h expected 1 0", obs_err, obs_rdo);
    end
    n_cmp++;
    if ({obs_err_post, obs_busy_post, obs_rd_post} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_after: err/busy/rd got %b expected 000",
                         {obs_err_post, obs_busy_post, obs_rd_post});
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd_word;
    @(posedge clk); #1;
    bus.mem_write = 3'd3; bus.alu_result = 32'h40; bus.out2 = $urandom; bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_wr, bus.busy_wait} !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_pre: wr/busy got %b expected 11", {bus.mem_wr, bus.busy_wait});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_wr, bus.busy_wait, bus.read_data_out} !== 34'd0) begin
      n_fail++; $display("FAIL rstmid_async: wr=%b busy=%b rdo=%h expected 0 0 0",
                         bus.mem_wr, bus.busy_wait, bus.read_data_out);
    end
    bus.mem_write = 3'd0;
    model_rdo = 32'd0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy_wait, bus.mem_wr, bus.mem_rd, bus.err, bus.read_data_out} !== 36'd0) begin
      n_fail++; $display("FAIL rstmid_ack_ignored: busy=%b wr=%b rd=%b err=%b rdo=%h expected all 0",
                         bus.busy_wait, bus.mem_wr, bus.mem_rd, bus.err, bus.read_data_out);
    end
    rd_word = $urandom;
    run_access(3'd3, 3'd0, 32'h44, 32'd0, rd_word, 1);
    model_rdo = rd_word;
    n_cmp++;
    if ({obs_busy == 2, obs_rdo} !== {1'b1, model_rdo}) begin
      n_fail++; $display("FAIL rstmid_idle: busy=%0d rdo=%h expected 2 %h", obs_busy, obs_rdo, model_rdo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  rd, wr;
    logic [31:0] addr, o2, rdat;
    int ack_at, size, off, exp_busy;
    bit st, mis, start;
    for (int i = 0; i < 40; i++) begin
      rd     = 3'($urandom_range(0, 7));
      wr     = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      addr   = $urandom; o2 = $urandom; rdat = $urandom;
      ack_at = $urandom_range(1, 4);
      size   = acc_size(rd, wr);
      st     = is_store(wr);
      off    = int'(addr[1:0]);
      mis    = (size != 0) && ((off % size) != 0);
      start  = (size != 0) && !mis;
      exp_busy = start ? 1 + ack_at : 0;
      run_access(rd, wr, addr, o2, rdat, ack_at);
      if (start && !st) model_rdo = ref_load(rd, off, rdat);
      n_cmp++;
      if ({obs_mis, obs_busy == exp_busy, obs_rdo} !== {mis, 1'b1, model_rdo}) begin
        n_fail++; $display("FAIL rand_%0d_result: mis=%b busy=%0d rdo=%h expected %b %0d %h (rd=%0d wr=%0d a=%h)",
                           i, obs_mis, obs_busy, obs_rdo, mis, exp_busy, model_rdo, rd, wr, addr);
      end
      if (start) begin
        n_cmp++;
        if ({obs_rd, obs_wr, obs_addr, obs_be} !==
            {!st, st, addr[31:2], st ? ref_be(size, off) : 4'b1111}) begin
          n_fail++; $display("FAIL rand_%0d_req: rd=%b wr=%b addr=%h be=%b (code rd=%0d wr=%0d a=%h)",
                             i, obs_rd, obs_wr, obs_addr, obs_be, rd, wr, addr);
        end
        if (st) begin
          n_cmp++;
          if (obs_wdata !== ref_wdata(size, o2)) begin
            n_fail++; $display("FAIL rand_%0d_wdata: got %h expected %h", i, obs_wdata, ref_wdata(size, o2));
          end
        end
      end
      n_cmp++;
      if ({obs_busy_post, obs_rd_post, obs_wr_post, obs_err_post, obs_err} !== 5'b00000) begin
        n_fail++; $display("FAIL rand_%0d_after: busy/rd/wr/err/err_done got %b expected 00000",
                           i, {obs_busy_post, obs_rd_post, obs_wr_post, obs_err_post, obs_err});
      end
    end
  endtask

  task automatic test_ack_outside_wait();
    @(posedge clk); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy_wait, bus.mem_rd, bus.mem_wr, bus.err, bus.read_data_out} !== {4'b0000, model_rdo}) begin
      n_fail++; $display("FAIL idle_ack: busy=%b rd=%b wr=%b err=%b rdo=%h expected 0 0 0 0 %h",
                         bus.busy_wait, bus.mem_rd, bus.mem_wr, bus.err, bus.read_data_out, model_rdo);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_read = 3'd0; bus.mem_write = 3'd0; bus.alu_result = 32'd0;
    bus.out2 = 32'd0; bus.mem_rdata = 32'd0; bus.mem_ack = 1'b0;
    model_rdo = 32'd0;
    test_reset();
    test_lb_sign();
    test_sh();
    test_both_valid();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_ack_outside_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
